// File: rtl/rf_writeback_if.sv
// Writeback stage bus: ALU result, LSU handshake, regfile write port and hazard checks.
interface rf_writeback_if #(
   parameter int unsigned XLEN = 32
);
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic [4:0]      rd;
   logic [XLEN-1:0] write_data;
   logic            wr_en;
   logic [4:0]      chk1_addr;
   logic [4:0]      chk2_addr;
   logic            chk1_pending;
   logic            chk2_pending;

   // Driver side: ALU, LSU and decode.
   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      input  lsu_ready,
      input  rd, write_data, wr_en,
      output chk1_addr, chk2_addr,
      input  chk1_pending, chk2_pending
   );

   // Writeback stage side.
   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      output lsu_ready,
      output rd, write_data, wr_en,
      input  chk1_addr, chk2_addr,
      output chk1_pending, chk2_pending
   );
endinterface

// File: rtl/rf_writeback.sv
// Writeback stage: owns the regfile write port, merges ALU results (priority)
// with queued LSU/MUL results, and reports outstanding writes for decode hazards.
module rf_writeback #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input logic           clk,
   input logic           reset,
   rf_writeback_if.slave wb
);

   localparam logic [PTR_W:0] FullCnt = (PTR_W+1)'(DEPTH);

   logic [4:0]      q_rd_q   [DEPTH];
   logic [4:0]      q_rd_d   [DEPTH];
   logic [XLEN-1:0] q_data_q [DEPTH];
   logic [XLEN-1:0] q_data_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;

   logic            wr_en_q, wr_en_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] wdata_q, wdata_d;

   logic             alu_eff;
   logic             lsu_ready;
   logic             push;
   logic             pop;
   logic [DEPTH-1:0] entry_vld;
   logic             chk1_pending;
   logic             chk2_pending;

   assign alu_eff   = wb.alu_valid && (wb.alu_rd != 5'd0);
   assign lsu_ready = (count_q < FullCnt);
   // x0 results complete the handshake but are dropped.
   assign push      = wb.lsu_valid && lsu_ready && (wb.lsu_rd != 5'd0);
   assign pop       = !alu_eff && (count_q != '0);

   // Output register next state: ALU first, then queue head, else idle (rd/data hold).
   always_comb begin
      wr_en_d = 1'b0;
      rd_d    = rd_q;
      wdata_d = wdata_q;
      if (alu_eff) begin
         wr_en_d = 1'b1;
         rd_d    = wb.alu_rd;
         wdata_d = wb.alu_data;
      end else if (pop) begin
         wr_en_d = 1'b1;
         rd_d    = q_rd_q[head_q];
         wdata_d = q_data_q[head_q];
      end
   end

   // Queue next state: pointers wrap naturally since DEPTH is a power of 2.
   always_comb begin
      q_rd_d   = q_rd_q;
      q_data_d = q_data_q;
      if (push) begin
         q_rd_d[tail_q]   = wb.lsu_rd;
         q_data_d[tail_q] = wb.lsu_data;
      end
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(push);
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
   end

   // An entry is live when its distance from head is below the occupancy count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entry_vld[i] = {1'b0, (PTR_W'(i) - head_q)} < count_q;
      end
   end

   // Hazard check against the presented write and every live queue entry.
   always_comb begin
      chk1_pending = wr_en_q && (rd_q == wb.chk1_addr);
      chk2_pending = wr_en_q && (rd_q == wb.chk2_addr);
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_vld[i] && (q_rd_q[i] == wb.chk1_addr)) chk1_pending = 1'b1;
         if (entry_vld[i] && (q_rd_q[i] == wb.chk2_addr)) chk2_pending = 1'b1;
      end
      if (wb.chk1_addr == 5'd0) chk1_pending = 1'b0;
      if (wb.chk2_addr == 5'd0) chk2_pending = 1'b0;
   end

   // State registers; reset discards queued and in-flight writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_rd_q[i]   <= '0;
            q_data_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         wr_en_q <= 1'b0;
         rd_q    <= '0;
         wdata_q <= '0;
      end else begin
         q_rd_q   <= q_rd_d;
         q_data_q <= q_data_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         wr_en_q  <= wr_en_d;
         rd_q     <= rd_d;
         wdata_q  <= wdata_d;
      end
   end

   assign wb.lsu_ready    = lsu_ready;
   assign wb.wr_en        = wr_en_q;
   assign wb.rd           = rd_q;
   assign wb.write_data   = wdata_q;
   assign wb.chk1_pending = chk1_pending;
   assign wb.chk2_pending = chk2_pending;

endmodule
